// File: rtl/dsp_acc_pkg.sv
// Shared types, widths and the result-saturation helper for the dsp_acc_32 dot-product accumulator.
package dsp_acc_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 48;
  localparam int BW      = 16;
  localparam int ACC_MAX = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] acc;
    logic [DW_DEF-1:0] data;
    logic [BW-1:0]     beats;
    logic              ovf;
  } acc_entry_t;

  typedef struct packed {
    logic               ovf;
    logic [ACC_MAX-1:0] data;
  } sat_res_t;

  // Narrow a sign-extended sum to dw signed bits; ovf flags any change of value.
  function automatic sat_res_t saturate(input logic signed [ACC_MAX-1:0] sum,
                                        input int unsigned dw,
                                        input logic sat_en);
    logic signed [ACC_MAX-1:0] max_v;
    logic signed [ACC_MAX-1:0] min_v;
    logic signed [ACC_MAX-1:0] fit_v;
    sat_res_t res;
    max_v = ({{(ACC_MAX-1){1'b0}}, 1'b1} <<< (dw - 1)) - {{(ACC_MAX-1){1'b0}}, 1'b1};
    min_v = ~max_v;
    fit_v = (sum <<< (ACC_MAX - dw)) >>> (ACC_MAX - dw);
    res.ovf = (fit_v != sum);
    if (sat_en && (sum > max_v)) begin
      res.data = max_v;
    end else if (sat_en && (sum < min_v)) begin
      res.data = min_v;
    end else begin
      res.data = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_acc_if.sv
// Product-in / result-out handshake bundle between the MAC column, the accumulator and write-back.
interface dsp_acc_if
  import dsp_acc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_acc;
  logic [BW-1:0] out_beats;
  logic          out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_acc, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_acc, out_beats, out_ovf
  );
endinterface

// File: rtl/dsp_acc_fifo.sv
// Result FIFO with a registered head: dout always shows the oldest entry, held when the FIFO empties.
module dsp_acc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  dout_r;

  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] rd_next_s;
  logic [CW-1:0] count_next_s;
  logic [W-1:0]  head_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign dout  = dout_r;

  // Next-state pointers and the entry that becomes the head after this edge.
  always_comb begin
    push_s       = push & ~full;
    pop_s        = pop & ~empty;
    rd_next_s    = pop_s ? (rd_ptr_r + PW'(1'b1)) : rd_ptr_r;
    count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // Storage array; contents are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      dout_r   <= {W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      if (count_next_s != {CW{1'b0}}) begin
        dout_r <= head_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end
endmodule

// File: rtl/dsp_acc_32.sv
// Dot-product accumulator: sums signed product beats per vector and queues the finished sums.
module dsp_acc_32
  import dsp_acc_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ce,
  input  logic     clr,
  dsp_acc_if.slave bus
);
  typedef struct packed {
    logic [AW-1:0] acc;
    logic [DW-1:0] data;
    logic [BW-1:0] beats;
    logic          ovf;
  } entry_t;

  localparam logic [BW-1:0] BEAT_ONE = {{(BW-1){1'b0}}, 1'b1};

  logic [1:0]    rst_sync_r;
  logic          rst_int_n;
  acc_state_e    state_r;
  logic [AW-1:0] acc_r;
  logic [BW-1:0] beats_r;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          push_s;
  logic [AW-1:0] sum_s;
  logic [BW-1:0] beats_next_s;
  sat_res_t      sat_res_s;
  logic          unused_sat_hi_s;
  entry_t        push_entry_s;
  entry_t        fifo_dout_s;

  // Reset asserts asynchronously but is released two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_r[1];

  assign in_ready_s = rst_int_n & ce & ~clr & ~fifo_full_s;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign push_s     = accept_s & bus.in_last;

  // Running sum including the current beat, plus its narrowed/flagged form.
  always_comb begin
    sum_s = ((state_r == ACCUM) ? acc_r : {AW{1'b0}})
          + {{(AW-DW){bus.in_data[DW-1]}}, bus.in_data};
    if (state_r == IDLE) begin
      beats_next_s = BEAT_ONE;
    end else if (beats_r == {BW{1'b1}}) begin
      beats_next_s = beats_r;
    end else begin
      beats_next_s = beats_r + BEAT_ONE;
    end
    sat_res_s          = saturate({{(ACC_MAX-AW){sum_s[AW-1]}}, sum_s}, DW, SAT);
    push_entry_s.acc   = sum_s;
    push_entry_s.data  = sat_res_s.data[DW-1:0];
    push_entry_s.beats = beats_next_s;
    push_entry_s.ovf   = sat_res_s.ovf;
  end
  assign unused_sat_hi_s = ^sat_res_s.data[ACC_MAX-1:DW];

  // Vector FSM: a LAST beat always ends the vector and restarts from an empty sum.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_r <= IDLE;
      acc_r   <= {AW{1'b0}};
      beats_r <= {BW{1'b0}};
    end else if (clr) begin
      state_r <= IDLE;
      acc_r   <= {AW{1'b0}};
      beats_r <= {BW{1'b0}};
    end else if (accept_s) begin
      case (state_r)
        IDLE, ACCUM: begin
          if (bus.in_last) begin
            state_r <= IDLE;
            acc_r   <= {AW{1'b0}};
            beats_r <= {BW{1'b0}};
          end else begin
            state_r <= ACCUM;
            acc_r   <= sum_s;
            beats_r <= beats_next_s;
          end
        end
        default: begin
          state_r <= IDLE;
          acc_r   <= {AW{1'b0}};
          beats_r <= {BW{1'b0}};
        end
      endcase
    end else begin
      state_r <= state_r;
      acc_r   <= acc_r;
      beats_r <= beats_r;
    end
  end

  dsp_acc_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_int_n),
    .clr   (clr),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (bus.out_ready),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = ~fifo_empty_s;
  assign bus.out_acc   = fifo_dout_s.acc;
  assign bus.out_data  = fifo_dout_s.data;
  assign bus.out_beats = fifo_dout_s.beats;
  assign bus.out_ovf   = fifo_dout_s.ovf;
endmodule

// File: tb/tb_dsp_acc_32.sv
// Self-checking bench for dsp_acc_32: directed scenarios plus random traffic against a queue-based model.
module tb_dsp_acc_32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [47:0] acc;
    logic [31:0] data;
    logic [15:0] beats;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic clr;

  exp_t   q[$];
  exp_t   last_head;
  longint vsum;
  int     vbeats;
  int     checks = 0;
  int     passed = 0;

  always #5 clk = ~clk;

  dsp_acc_if #(.DW(32), .AW(48)) bus ();

  dsp_acc_32 #(.DW(32), .AW(48), .DEPTH(DEPTH), .SAT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (clr),
    .bus   (bus)
  );

  function automatic exp_t make_result(input longint s, input int n);
    longint w;
    exp_t   r;
    w = (s <<< 16) >>> 16;
    r.acc   = w[47:0];
    r.beats = n[15:0];
    if (w > 64'sd2147483647) begin
      r.data = 32'h7FFF_FFFF;
      r.ovf  = 1'b1;
    end else if (w < -64'sd2147483648) begin
      r.data = 32'h8000_0000;
      r.ovf  = 1'b1;
    end else begin
      r.data = w[31:0];
      r.ovf  = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    q.delete();
    vsum      = 0;
    vbeats    = 0;
    last_head = '{acc: 48'h0, data: 32'h0, beats: 16'h0, ovf: 1'b0};
  endfunction

  task automatic cycle();
    logic exp_ready;
    logic do_pop;
    logic do_acc;
    @(negedge clk);
    exp_ready = ce && !clr && (q.size() < DEPTH);
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) last_head = q[0];
    chk("out_fields", {bus.out_acc, bus.out_data, bus.out_beats, bus.out_ovf},
        {last_head.acc, last_head.data, last_head.beats, last_head.ovf});
    do_pop = bus.out_ready && (q.size() > 0);
    do_acc = bus.in_valid && exp_ready;
    @(posedge clk);
    if (clr) begin
      q.delete();
      vsum   = 0;
      vbeats = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_acc) begin
        vsum += longint'(signed'(bus.in_data));
        if (vbeats < 65535) vbeats++;
        if (bus.in_last) begin
          q.push_back(make_result(vsum, vbeats));
          vsum   = 0;
          vbeats = 0;
        end
      end
    end
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    cycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; ce = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #20;
    chk("rst_outputs", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_acc, bus.out_beats, bus.out_ovf}, 100'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 ce = 1'b1;

    // 3, -5, 10 -> 8
    beat(32'd3, 1'b0); beat(-32'sd5, 1'b0); beat(32'd10, 1'b1);
    chk("dot_valid", bus.out_valid, 1'b1);
    chk("dot_data", bus.out_data, 32'd8);
    chk("dot_acc", bus.out_acc, 48'd8);
    chk("dot_beats_ovf", {bus.out_beats, bus.out_ovf}, {16'd3, 1'b0});
    cycle();
    pop_one();

    // positive and negative saturation
    beat(32'h7FFF_FFFF, 1'b0); beat(32'h0000_0002, 1'b1);
    chk("satp_data", bus.out_data, 32'h7FFF_FFFF);
    chk("satp_acc", bus.out_acc, 48'h0000_8000_0001);
    chk("satp_ovf", bus.out_ovf, 1'b1);
    pop_one();
    beat(32'h8000_0000, 1'b0); beat(32'h8000_0000, 1'b1);
    chk("satn_data", bus.out_data, 32'h8000_0000);
    chk("satn_acc_ovf", {bus.out_acc, bus.out_ovf}, {48'hFFFF_0000_0000, 1'b1});
    pop_one();

    // fill the FIFO, then pop and push in the same cycle while full
    for (int i = 1; i <= 4; i++) beat(32'(i), 1'b1);
    chk("full_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'd5; bus.in_last = 1'b1; bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("reassert_ready", bus.in_ready, 1'b1);
    cycle();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("drain_order", bus.out_data, 32'(k));
      cycle();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", bus.out_valid, 1'b0);

    // mid-vector clear with a beat in flight and a queued result
    beat(32'd9, 1'b1); beat(32'd7, 1'b0); beat(32'd7, 1'b0);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'd100; bus.in_last = 1'b1;
    cycle();
    clr = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("clr_flushed", bus.out_valid, 1'b0);
    beat(32'd1, 1'b1);
    chk("clr_result", {bus.out_valid, bus.out_data, bus.out_beats}, {1'b1, 32'd1, 16'd1});

    // clock enable low mid-vector; the consumer still drains
    beat(32'd4, 1'b0);
    ce = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'd50; bus.out_ready = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b0; ce = 1'b1;
    beat(32'd6, 1'b1);
    chk("ce_result", {bus.out_data, bus.out_beats}, {32'd10, 16'd2});

    // asynchronous reset mid-vector
    beat(32'd20, 1'b0); beat(32'd30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_acc, bus.out_beats, bus.out_ovf}, 100'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    beat(32'd11, 1'b1);
    chk("post_rst", {bus.out_data, bus.out_beats}, {32'd11, 16'd1});

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ce            = ($urandom_range(0, 9) != 0);
      clr           = ($urandom_range(0, 49) == 0);
      bus.in_valid  = $urandom_range(0, 1) != 0;
      bus.in_data   = ($urandom_range(0, 1) != 0) ? $urandom() : ($urandom_range(0, 200) - 32'd100);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    ce = 1'b1; clr = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (6) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dsp_acc_32.md
Name: dsp_acc_32

Overview:
- Downstream consumer of the signed 32-bit multiplier stage.
- Accumulates a stream of signed 32-bit products into a wide accumulator, one dot product per vector; IN_LAST marks the final beat of each vector.
- Optionally saturates each finished sum to 32 bits and queues it in a small output FIFO with valid/ready.
- Sits between the MAC column and the result write-back to the output buffer.

Parameters:
- DW, 32, product and result data width.
- AW, 48, internal accumulator width; AW >= DW+16 is required.
- DEPTH, 4, output FIFO depth in entries; power of two, >= 2.
- SAT, 1, 1 = saturate the result to DW signed bits, 0 = truncate to the low DW bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable; when low, all state holds and IN_READY=0.
- CLR  in  1  synchronous clear: drops the partial sum and empties the FIFO.
- IN_VALID  in  1  product beat valid.
- IN_DATA  in  DW  signed product.
- IN_LAST  in  1  final beat of the current vector.
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts the FIFO head.
- OUT_DATA  out  DW  saturated or truncated sum.
- OUT_ACC  out  AW  full-width sum (for chaining into PCIN).
- OUT_BEATS  out  16  number of beats in the vector, saturating at 0xFFFF.
- OUT_OVF  out  1  set when saturation or truncation changed the value.

Behaviour:
- Reset (RESETN=0, async): acc=0, beats=0, state=IDLE, FIFO empty. Outputs: OUT_VALID=0, IN_READY=0, OUT_DATA=0, OUT_ACC=0, OUT_BEATS=0, OUT_OVF=0. Deassertion is synchronised internally.
- IN_READY = CE & !CLR & !fifo_full. No combinational path from OUT_READY to IN_READY.
- FSM states:
  - IDLE: the accepted beat loads acc = sext(IN_DATA) and beats=1, then goes to ACCUM. If IN_LAST is also set, the result is pushed and the FSM stays in IDLE.
  - ACCUM: each accepted beat does acc += sext(IN_DATA) and beats+1 (saturating). An accepted beat with IN_LAST pushes {acc+IN_DATA, beats+1} and returns to IDLE, with acc=0 and beats=0.
- Arithmetic: AW-bit two's-complement accumulation, wraps at AW bits (not flagged).
- SAT=1: sum > 2^(DW-1)-1 gives 0x7FFFFFFF; sum < -2^(DW-1) gives 0x80000000; OVF=1 in either case.
- SAT=0: OUT_DATA = sum[DW-1:0]; OVF=1 if the upper bits are not a sign extension.
- Latency: IN_LAST accepted at edge N into an empty FIFO gives OUT_VALID=1 after edge N (visible in cycle N+1). Outputs are registered from FIFO storage.
- FIFO push and pop in the same cycle are both honoured and the count is unchanged.
- Full FIFO: IN_READY=0 even if OUT_READY=1 that cycle; it reasserts the cycle after the pop.
- Empty FIFO: OUT_READY is ignored; the outputs hold their last values with OUT_VALID=0.
- CE=0: no accept, no FSM or acc change. FIFO pop is still allowed, so the consumer can drain.
- CLR=1 (priority over everything except RESETN): acc=0, beats=0, IDLE, FIFO empty on the next edge. An in-flight beat in that cycle is discarded.
- Reset mid-vector: the partial sum is lost with no output.
- OUT_ACC/OUT_DATA/OUT_BEATS/OUT_OVF stay stable while OUT_VALID & !OUT_READY.

Decomposition:
- Package dsp_acc_pkg holds:
  - DW/AW defaults and the 16-bit beat-count width.
  - The state enum {IDLE, ACCUM}.
  - The FIFO entry typedef {acc[AW], data[DW], beats[16], ovf}.
  - A saturate function.
- Sub-module dsp_acc_fifo: synchronous FIFO of DEPTH entries with registered outputs, simultaneous push/pop, full/empty flags, and async active-low reset.

Test Plan:
- Vector 3,-5,10 with LAST on 10 -> OUT_DATA=8, OUT_ACC=8, OUT_BEATS=3, OUT_OVF=0, OUT_VALID one cycle after the LAST accept.
- SAT=1, two beats 0x7FFFFFFF + 0x00000002 -> OUT_DATA=0x7FFFFFFF, OUT_ACC=0x000080000001, OVF=1. With -2^31 twice -> 0x80000000, OVF=1.
- OUT_READY=0, five 1-beat vectors of values 1..5 -> four queued, IN_READY=0 on the 5th. Pulse OUT_READY for one cycle -> pops 1, 5 accepted next cycle; drain order 2,3,4,5.
- Full FIFO with IN_LAST valid and OUT_READY=1 in the same cycle -> pop occurs, push deferred exactly one cycle, no loss or duplication.
- Mid-vector CLR after beats 7,7: next vector 1,LAST -> OUT_DATA=1, BEATS=1, FIFO contents flushed.
- CE=0 for 3 cycles mid-vector with IN_VALID=1 -> no accept, acc unchanged. RESETN pulsed low asynchronously mid-vector -> all outputs 0 and OUT_VALID=0 immediately.
